// File: rtl/frame_ram_arbiter.sv
// Frame RAM arbiter: shares one synchronous RAM port between display-scan reads and
// command writes, favouring reads while bounding how long a pending write can wait.
module frame_ram_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable,
  output logic                  busy
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_RD   = 2'd1,
    GRANT_WR   = 2'd2
  } grant_e;

  grant_e                grant_s;
  logic [3:0]            starve_nxt_s;
  logic [3:0]            starve_cnt_r;
  logic                  rd_ack_r;
  logic                  wr_ack_r;
  logic                  rd_stage_r;
  logic                  rd_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [ADDR_WIDTH-1:0] ram_address_r;
  logic [DATA_WIDTH-1:0] ram_data_out_r;
  logic                  ram_write_enable_r;
  logic                  ram_clk_enable_r;
  logic                  busy_r;

  // Grant decision and write-starvation counter update for this edge.
  always_comb begin
    grant_s      = GRANT_NONE;
    starve_nxt_s = starve_cnt_r;
    if (rd_req && wr_req) begin
      if (starve_cnt_r == STARVE_MAX) begin
        grant_s = GRANT_WR;
      end else begin
        grant_s = GRANT_RD;
      end
    end else if (rd_req) begin
      grant_s = GRANT_RD;
    end else if (wr_req) begin
      grant_s = GRANT_WR;
    end else begin
      grant_s = GRANT_NONE;
    end

    // A write that is not waiting, or has just won, owes nothing.
    if (!wr_req || (grant_s == GRANT_WR)) begin
      starve_nxt_s = 4'd0;
    end else if (starve_cnt_r != STARVE_MAX) begin
      starve_nxt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Registered RAM command, acknowledges and the two-stage read return pipeline.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      starve_cnt_r       <= 4'd0;
      rd_ack_r           <= 1'b0;
      wr_ack_r           <= 1'b0;
      rd_stage_r         <= 1'b0;
      rd_valid_r         <= 1'b0;
      rd_data_r          <= '0;
      ram_address_r      <= '0;
      ram_data_out_r     <= '0;
      ram_write_enable_r <= 1'b0;
      ram_clk_enable_r   <= 1'b0;
      busy_r             <= 1'b0;
    end else begin
      starve_cnt_r       <= starve_nxt_s;
      rd_ack_r           <= (grant_s == GRANT_RD);
      wr_ack_r           <= (grant_s == GRANT_WR);
      ram_write_enable_r <= (grant_s == GRANT_WR);
      ram_clk_enable_r   <= (grant_s != GRANT_NONE);
      case (grant_s)
        GRANT_RD: begin
          ram_address_r <= rd_addr;
        end
        GRANT_WR: begin
          ram_address_r  <= wr_addr;
          ram_data_out_r <= wr_data;
        end
        GRANT_NONE: begin
          ram_address_r <= ram_address_r;
        end
        default: begin
          ram_address_r <= ram_address_r;
        end
      endcase
      // RAM samples the address while rd_ack is high; its data is captured one edge later.
      rd_stage_r <= rd_ack_r;
      rd_valid_r <= rd_stage_r;
      if (rd_stage_r) begin
        rd_data_r <= ram_data_in;
      end else begin
        rd_data_r <= rd_data_r;
      end
      busy_r <= (grant_s == GRANT_RD) || rd_ack_r;
    end
  end

  assign rd_ack           = rd_ack_r;
  assign wr_ack           = wr_ack_r;
  assign rd_valid         = rd_valid_r;
  assign rd_data          = rd_data_r;
  assign ram_address      = ram_address_r;
  assign ram_data_out     = ram_data_out_r;
  assign ram_write_enable = ram_write_enable_r;
  assign ram_clk_enable   = ram_clk_enable_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Bench for frame_ram_arbiter: directed vector table, corner-case sequences and a
// randomized run checked against a transaction-level model with a shadow memory.
module tb_frame_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int SL = 4;

  logic          clk_in;
  logic          reset;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_out;
  logic [DW-1:0] ram_data_in;
  logic          ram_write_enable;
  logic          ram_clk_enable;
  logic          busy;

  frame_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk_in(clk_in), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_address(ram_address), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_clk_enable(ram_clk_enable), .busy(busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Synchronous RAM: data out is valid the cycle after the access edge.
  logic [DW-1:0] ram_mem [4096];
  logic          mem_init_done = 1'b0;
  always @(posedge clk_in) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 4096; i++) ram_mem[i] <= 8'(i) ^ 8'h79;
      mem_init_done <= 1'b1;
    end else if (ram_clk_enable) begin
      if (ram_write_enable) ram_mem[ram_address] <= ram_data_out;
      else ram_data_in <= ram_mem[ram_address];
    end
  end

  typedef struct {
    logic          rst;
    logic          rd;
    logic [AW-1:0] ra;
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          e_rack;
    logic          e_wack;
    logic          e_ce;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dout;
    logic          e_valid;
    logic [DW-1:0] e_rdata;
    logic          e_busy;
  } vec_t;

  typedef struct {
    int            acc;
    logic [DW-1:0] data;
  } rd_t;

  // Reference model: shadow memory updated in acceptance order, reads in flight by cycle.
  logic [DW-1:0] ref_mem [4096];
  rd_t           inflight [$];
  int            cyc = 0;
  int            lost = 0;
  int            m_grant = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_dout = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_valid = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rd, input logic [AW-1:0] ra,
                      input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int g;
    reset = rst; rd_req = rd; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
    cyc++;
    g = 0;
    if (rst) begin
      inflight.delete();
      lost = 0; m_addr = '0; m_dout = '0; m_rdata = '0;
    end else begin
      if (rd && wr) g = (lost == SL) ? 2 : 1;
      else if (rd) g = 1;
      else if (wr) g = 2;
      if (!wr || g == 2) lost = 0;
      else if (lost < SL) lost++;
      if (g == 1) begin
        inflight.push_back('{cyc, ref_mem[ra]});
        m_addr = ra;
      end
      if (g == 2) begin
        ref_mem[wa] = wd;
        m_addr = wa;
        m_dout = wd;
      end
    end
    m_valid = 1'b0;
    if (inflight.size() > 0 && inflight[0].acc + 2 == cyc) begin
      m_valid = 1'b1;
      m_rdata = inflight[0].data;
      void'(inflight.pop_front());
    end
    m_grant = g;
    @(posedge clk_in);
    #1;
    chk("rd_ack", 32'(rd_ack), 32'(g == 1));
    chk("wr_ack", 32'(wr_ack), 32'(g == 2));
    chk("ram_clk_enable", 32'(ram_clk_enable), 32'(g != 0));
    chk("ram_write_enable", 32'(ram_write_enable), 32'(g == 2));
    chk("ram_address", 32'(ram_address), 32'(m_addr));
    chk("ram_data_out", 32'(ram_data_out), 32'(m_dout));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("rd_data", 32'(rd_data), 32'(m_rdata));
    chk("busy", 32'(busy), 32'(inflight.size() != 0));
  endtask

  vec_t tbl [14];

  initial begin
    logic          rp, wp, seen_w;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    int            n_rd_before, n_cnt;

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i) ^ 8'h79;
    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;

    // rst rd ra wr wa wd | rack wack ce we addr dout valid rdata busy
    tbl[0]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 12'h123, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 12'h123, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 8'h00, 1'b0, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 8'h00, 1'b1, 8'h5A, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h7FF, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 12'h7FF, 8'hC3, 1'b0, 8'h5A, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 12'h7FF, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 12'h7FF, 8'hC3, 1'b0, 8'h5A, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h7FF, 8'hC3, 1'b0, 8'h5A, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h7FF, 8'hC3, 1'b1, 8'hC3, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 12'h000, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 8'hC3, 1'b0, 8'hC3, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 12'h001, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 12'h001, 8'hC3, 1'b0, 8'hC3, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 12'h002, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 12'h002, 8'hC3, 1'b1, 8'h79, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h002, 8'hC3, 1'b1, 8'h78, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h002, 8'hC3, 1'b1, 8'h7B, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h002, 8'hC3, 1'b0, 8'h7B, 1'b0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].rd, tbl[i].ra, tbl[i].wr, tbl[i].wa, tbl[i].wd);
      chk("tbl_rd_ack", 32'(rd_ack), 32'(tbl[i].e_rack));
      chk("tbl_wr_ack", 32'(wr_ack), 32'(tbl[i].e_wack));
      chk("tbl_clk_en", 32'(ram_clk_enable), 32'(tbl[i].e_ce));
      chk("tbl_wr_en", 32'(ram_write_enable), 32'(tbl[i].e_we));
      chk("tbl_addr", 32'(ram_address), 32'(tbl[i].e_addr));
      chk("tbl_dout", 32'(ram_data_out), 32'(tbl[i].e_dout));
      chk("tbl_rd_valid", 32'(rd_valid), 32'(tbl[i].e_valid));
      chk("tbl_rd_data", 32'(rd_data), 32'(tbl[i].e_rdata));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
    end

    // Starvation: reads held continuously, a write waiting alongside.
    ra = 12'h010; n_rd_before = 0; seen_w = 1'b0;
    for (int i = 0; i < 10 && !seen_w; i++) begin
      step(1'b0, 1'b1, ra, 1'b1, 12'h0AA, 8'h3C);
      if (wr_ack) seen_w = 1'b1;
      else if (rd_ack) n_rd_before++;
      if (m_grant == 1) ra = ra + 12'h001;
    end
    chk("starve_write_seen", 32'(seen_w), 32'd1);
    chk("starve_reads_before_write", 32'(n_rd_before), 32'd4);
    step(1'b0, 1'b1, ra, 1'b0, 12'h000, 8'h00);
    chk("starve_reads_resume", 32'(rd_ack), 32'd1);
    step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
    step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00);

    // Reset with two reads in flight, then a fresh read.
    step(1'b0, 1'b1, 12'h005, 1'b0, 12'h000, 8'h00);
    step(1'b0, 1'b1, 12'h006, 1'b0, 12'h000, 8'h00);
    step(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
    n_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      if (rd_valid) n_cnt++;
    end
    chk("reset_drops_reads", 32'(n_cnt), 32'd0);
    step(1'b0, 1'b1, 12'h123, 1'b0, 12'h000, 8'h00);
    step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
    step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
    chk("post_reset_valid", 32'(rd_valid), 32'd1);
    chk("post_reset_data", 32'(rd_data), 32'h5A);

    // Idle for ten cycles.
    n_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 8'h00);
      if (ram_clk_enable || ram_write_enable || rd_ack || wr_ack) n_cnt++;
    end
    chk("idle_no_activity", 32'(n_cnt), 32'd0);

    // Randomized traffic on a small address window to provoke same-address hazards.
    rp = 1'b0; wp = 1'b0; ra = '0; wa = '0; wd = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!rp && $urandom_range(0, 3) != 0) begin
        rp = 1'b1; ra = 12'($urandom_range(0, 15));
      end else if (rp && $urandom_range(0, 19) == 0) begin
        rp = 1'b0;
      end
      if (!wp && $urandom_range(0, 2) == 0) begin
        wp = 1'b1; wa = 12'($urandom_range(0, 15)); wd = 8'($urandom);
      end else if (wp && $urandom_range(0, 29) == 0) begin
        wp = 1'b0;
      end
      step(($urandom_range(0, 99) == 0), rp, ra, wp, wa, wd);
      if (m_grant == 1) rp = 1'b0;
      if (m_grant == 2) wp = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
